delayed_data_memory: RTL and testbench

Multi-cycle data memory for the 5-stage MIPS pipeline, serving the M stage. It accepts one load or store at a time and completes it a fixed `LATENCY` cycles later. Loads return read data together with their destination register tag. Busy and completion strobes drive the hazard logic, which stalls dependent, branch and memory-op instructions while a transaction is in flight.

---
 rtl/delayed_data_memory.sv | 145 ++++++++++++++
 tb/tb_delayed_data_memory.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/delayed_data_memory.sv
`default_nettype none
// ============================================================================
// Module  : delayed_data_memory
// Brief   : Single-outstanding data memory for the M stage. Each load or store
//           commits a fixed LATENCY cycles after it is accepted.
// Revision: 1.0
// ============================================================================
module delayed_data_memory #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        Busy,
    output logic        ReadValid,
    output logic [31:0] ReadDataW,
    output logic [4:0]  ReadTagW,
    output logic        WriteDone,
    output logic        ReqDropped,
    output logic        BothOpErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT  = 4'(LATENCY - 1);
    localparam bit         C_IMMEDIATE = (LATENCY == 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [4:0]          tag_q;
    logic                read_valid_q, write_done_q, req_dropped_q, both_err_q;
    logic [31:0]         rdata_q;
    logic [4:0]          rtag_q;
    logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

    logic                w_req, w_accept, w_commit, w_c_wr;
    logic [ADDR_W-1:0]   w_req_addr, w_c_addr;
    logic [31:0]         w_c_data;
    logic [4:0]          w_c_tag;
    logic                w_unused_addr_bits;

    assign w_req      = MemReadM | MemWriteM;
    assign w_accept   = w_req && (state_q != S_WAIT);
    assign w_req_addr = ALUOutM[ADDR_W+1:2];
    assign w_unused_addr_bits = ^{ALUOutM[31:ADDR_W+2], ALUOutM[1:0]};

    // With LATENCY=1 the commit happens on the accepting edge itself, using
    // the request fields directly instead of the captured copies.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        w_c_wr   = op_wr_q;
        w_c_addr = addr_q;
        w_c_data = wdata_q;
        w_c_tag  = tag_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_DONE;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (w_accept) begin
                    if (C_IMMEDIATE) begin
                        state_d  = S_DONE;
                        w_commit = 1'b1;
                        w_c_wr   = MemWriteM;
                        w_c_addr = w_req_addr;
                        w_c_data = WriteDataM;
                        w_c_tag  = WriteRegM;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // The array is deliberately left out of the reset branch: contents survive CLR.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tag_q         <= '0;
            read_valid_q  <= 1'b0;
            write_done_q  <= 1'b0;
            req_dropped_q <= 1'b0;
            both_err_q    <= 1'b0;
            rdata_q       <= '0;
            rtag_q        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                op_wr_q <= MemWriteM;
                addr_q  <= w_req_addr;
                wdata_q <= WriteDataM;
                tag_q   <= WriteRegM;
            end
            read_valid_q  <= w_commit && !w_c_wr;
            write_done_q  <= w_commit && w_c_wr;
            req_dropped_q <= w_req && (state_q == S_WAIT);
            both_err_q    <= w_accept && MemReadM && MemWriteM;
            if (w_commit && w_c_wr) begin
                mem_q[w_c_addr] <= w_c_data;
            end
            if (w_commit && !w_c_wr) begin
                rdata_q <= mem_q[w_c_addr];
                rtag_q  <= w_c_tag;
            end
        end
    end

    assign Busy       = (state_q == S_WAIT);
    assign ReadValid  = read_valid_q;
    assign ReadDataW  = rdata_q;
    assign ReadTagW   = rtag_q;
    assign WriteDone  = write_done_q;
    assign ReqDropped = req_dropped_q;
    assign BothOpErr  = both_err_q;

endmodule
`default_nettype wire

// File: tb/tb_delayed_data_memory.sv
`default_nettype none
// ============================================================================
// Module  : tb_delayed_data_memory
// Brief   : Checks a LATENCY=3 and a LATENCY=1 instance against array models.
// Revision: 1.0
// ============================================================================
module tb_delayed_data_memory;

    localparam int L3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [4:0]  tag;
    logic        busy3, rv3, wd3, drop3, both3;
    logic [31:0] rdata3;
    logic [4:0]  rtag3;

    logic        d1_rd, d1_wr;
    logic [31:0] d1_addr, d1_wdata;
    logic [4:0]  d1_tag;
    logic        busy1, rv1, wd1, drop1, both1;
    logic [31:0] rdata1;
    logic [4:0]  rtag1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref3 [256];
    bit          known3 [256];
    logic [31:0] last_rd3;
    logic [4:0]  last_tag3;
    logic [31:0] ref1 [256];
    bit          known1 [256];
    logic [31:0] last_rd1;
    logic [4:0]  last_tag1;

    always #5 clk = ~clk;

    delayed_data_memory #(.ADDR_W(8), .LATENCY(L3)) u_dut3 (
        .CLK(clk), .CLR(rst), .MemReadM(rd), .MemWriteM(wr), .ALUOutM(addr),
        .WriteDataM(wdata), .WriteRegM(tag), .Busy(busy3), .ReadValid(rv3),
        .ReadDataW(rdata3), .ReadTagW(rtag3), .WriteDone(wd3),
        .ReqDropped(drop3), .BothOpErr(both3)
    );

    delayed_data_memory #(.ADDR_W(8), .LATENCY(1)) u_dut1 (
        .CLK(clk), .CLR(rst), .MemReadM(d1_rd), .MemWriteM(d1_wr), .ALUOutM(d1_addr),
        .WriteDataM(d1_wdata), .WriteRegM(d1_tag), .Busy(busy1), .ReadValid(rv1),
        .ReadDataW(rdata1), .ReadTagW(rtag1), .WriteDone(wd1),
        .ReqDropped(drop1), .BothOpErr(both1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the LATENCY=3 instance; returns in its completion cycle.
    // drop_at = k injects a load during the k-th busy cycle (-1: none).
    task automatic op3(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] t, input int drop_at);
        int idx = int'((a >> 2) % 256);
        bit is_store = w;
        rd = r; wr = w; addr = a; wdata = d; tag = t;
        tick();
        rd = 1'b0; wr = 1'b0;
        n_checks++;
        if (busy3 !== 1'b1 || rv3 !== 1'b0 || wd3 !== 1'b0)
            $display("FAIL accept_busy: got busy=%b rv=%b wd=%b, expected 1 0 0", busy3, rv3, wd3);
        if (busy3 !== 1'b1 || rv3 !== 1'b0 || wd3 !== 1'b0) n_fail++;
        n_checks++;
        if (both3 !== (r && w)) begin
            n_fail++;
            $display("FAIL both_op_err: got %b expected %b", both3, r && w);
        end
        for (int k = 1; k <= L3; k++) begin
            if (drop_at == k - 1) begin
                rd = 1'b1; addr = $urandom; tag = 5'($urandom);
            end
            tick();
            rd = 1'b0;
            if (k < L3) begin
                n_checks++;
                if (busy3 !== 1'b1 || rv3 !== 1'b0 || wd3 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_state: cycle %0d got busy=%b rv=%b wd=%b, expected 1 0 0", k, busy3, rv3, wd3);
                end
            end
            n_checks++;
            if (drop3 !== (drop_at == k - 1)) begin
                n_fail++;
                $display("FAIL req_dropped: cycle %0d got %b expected %b", k, drop3, drop_at == k - 1);
            end
        end
        if (is_store) begin
            ref3[idx] = d;
            known3[idx] = 1'b1;
        end else begin
            last_rd3 = ref3[idx];
            last_tag3 = t;
        end
        n_checks++;
        if (busy3 !== 1'b0 || rv3 !== !is_store || wd3 !== is_store) begin
            n_fail++;
            $display("FAIL done_strobes: got busy=%b rv=%b wd=%b, expected 0 %b %b", busy3, rv3, wd3, !is_store, is_store);
        end
        n_checks++;
        if (rdata3 !== last_rd3 || rtag3 !== last_tag3) begin
            n_fail++;
            $display("FAIL read_data: got %h/%0d expected %h/%0d", rdata3, rtag3, last_rd3, last_tag3);
        end
    endtask

    task automatic idle3(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (busy3 !== 1'b0 || rv3 !== 1'b0 || wd3 !== 1'b0 || drop3 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: got busy=%b rv=%b wd=%b drop=%b, expected all 0", busy3, rv3, wd3, drop3);
            end
        end
    endtask

    // One request per cycle on the LATENCY=1 instance.
    task automatic op1(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] t);
        int idx = int'((a >> 2) % 256);
        bit is_store = w;
        d1_rd = r; d1_wr = w; d1_addr = a; d1_wdata = d; d1_tag = t;
        tick();
        d1_rd = 1'b0; d1_wr = 1'b0;
        if (is_store) begin
            ref1[idx] = d;
            known1[idx] = 1'b1;
        end else begin
            last_rd1 = ref1[idx];
            last_tag1 = t;
        end
        n_checks++;
        if (busy1 !== 1'b0 || drop1 !== 1'b0 || rv1 !== !is_store || wd1 !== is_store || both1 !== (r && w)) begin
            n_fail++;
            $display("FAIL l1_strobes: got busy=%b drop=%b rv=%b wd=%b both=%b, expected 0 0 %b %b %b",
                     busy1, drop1, rv1, wd1, both1, !is_store, is_store, r && w);
        end
        n_checks++;
        if (rdata1 !== last_rd1 || rtag1 !== last_tag1) begin
            n_fail++;
            $display("FAIL l1_read_data: got %h/%0d expected %h/%0d", rdata1, rtag1, last_rd1, last_tag1);
        end
    endtask

    task automatic test_reset();
        op3(1'b0, 1'b1, 32'h10, 32'h1111_1111, 5'd0, -1);
        idle3(1);
        rd = 1'b0; wr = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF; tag = 5'd0;
        tick();
        wr = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy3, rv3, wd3, drop3, both3} !== 5'b0 || rdata3 !== 32'h0 || rtag3 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags=%b data=%h tag=%0d, expected 0", {busy3, rv3, wd3, drop3, both3}, rdata3, rtag3);
        end
        n_checks++;
        if ({busy1, rv1, wd1, drop1, both1} !== 5'b0 || rdata1 !== 32'h0 || rtag1 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_l1: got flags=%b data=%h tag=%0d, expected 0", {busy1, rv1, wd1, drop1, both1}, rdata1, rtag1);
        end
        repeat (2) tick();
        rst = 1'b0;
        last_rd3 = 32'h0; last_tag3 = 5'd0;
        op3(1'b1, 1'b0, 32'h10, 32'h0, 5'd3, -1);
        n_checks++;
        if (rdata3 === 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL reset_abandon: got %h required not DEADBEEF", rdata3);
        end
        idle3(1);
    endtask

    task automatic test_store_load();
        op3(1'b0, 1'b1, 32'h20, 32'h1234_5678, 5'd0, -1);
        op3(1'b1, 1'b0, 32'h20, 32'h0, 5'd9, -1);
        idle3(2);
    endtask

    task automatic test_drop();
        op3(1'b1, 1'b0, 32'h20, 32'h0, 5'd5, 1);
        idle3(3);
        op3(0, 1'b1, 32'h24, 32'hCAFE_0001, 5'd0, L3 - 1);
        idle3(1);
    endtask

    task automatic test_wrap();
        op3(1'b0, 1'b1, 32'h403, 32'hA5A5_A5A5, 5'd0, -1);
        idle3(1);
        op3(1'b1, 1'b0, 32'h000, 32'h0, 5'd1, -1);
        idle3(1);
    endtask

    task automatic test_both_ops();
        op3(1'b1, 1'b1, 32'h8, 32'h1, 5'd7, -1);
        op3(1'b1, 1'b0, 32'h8, 32'h0, 5'd2, -1);
        idle3(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                             | 32'($urandom_range(0, 3));
            int kind = int'($urandom_range(0, 2));
            bit r = (kind != 1);
            bit w = (kind != 0);
            if (r && !w && !known3[int'((a >> 2) % 256)]) begin
                r = 1'b0; w = 1'b1;
            end
            op3(r, w, a, $urandom, 5'($urandom), int'($urandom_range(0, 4)) - 1);
            if ($urandom_range(0, 1) == 1) idle3(1);
        end
        idle3(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            op1(1'b0, 1'b1, 32'hC0 + 32'(i * 4), $urandom, 5'd0);
        for (int i = 0; i < 4; i++)
            op1(1'b1, 1'b0, 32'hC0 + 32'(i * 4), 32'h0, 5'(i + 1));
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a = 32'hC0 + (32'($urandom_range(0, 5)) << 2);
            int kind = int'($urandom_range(0, 2));
            bit r = (kind != 1);
            bit w = (kind != 0);
            if (r && !w && !known1[int'((a >> 2) % 256)]) begin
                r = 1'b0; w = 1'b1;
            end
            op1(r, w, a, $urandom, 5'($urandom));
        end
        tick();
        n_checks++;
        if (rv1 !== 1'b0 || wd1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL l1_idle: got rv=%b wd=%b busy=%b expected 0 0 0", rv1, wd1, busy1);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; tag = '0;
        d1_rd = 1'b0; d1_wr = 1'b0; d1_addr = '0; d1_wdata = '0; d1_tag = '0;
        last_rd3 = '0; last_tag3 = '0; last_rd1 = '0; last_tag1 = '0;
        for (int i = 0; i < 256; i++) begin
            ref3[i] = '0; known3[i] = 1'b0; ref1[i] = '0; known1[i] = 1'b0;
        end
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_store_load();
        test_drop();
        test_wrap();
        test_both_ops();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
